stream_capture_buffer: RTL and testbench

STREAM_CAPTURE_BUFFER -- requirements
Module: stream_capture_buffer

---
 rtl/stream_capture_buffer_if.sv | 27 ++
 rtl/stream_capture_buffer.sv | 202 ++++++++++++++++++++
 tb/tb_stream_capture_buffer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_capture_buffer_if.sv
// Stream input and Wishbone classic target signals of stream_capture_buffer.
// The slave modport is the buffer itself; the master modport is its driver.
interface stream_capture_buffer_if;
  logic [127:0] buf_tdata;
  logic         buf_tvalid;
  logic         buf_tready;
  logic         wb_cyc_i;
  logic         wb_stb_i;
  logic         wb_we_i;
  logic [12:0]  wb_adr_i;
  logic [31:0]  wb_dat_i;
  logic [3:0]   wb_sel_i;
  logic [31:0]  wb_dat_o;
  logic         wb_ack_o;
  logic         wb_err_o;
  logic         wb_rty_o;

  modport master (
    output buf_tdata, buf_tvalid, wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  buf_tready, wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  buf_tdata, buf_tvalid, wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output buf_tready, wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/stream_capture_buffer.sv
// Triggered capture of a 128-bit stream into on-chip memory.
// Control, status and the captured data are reached through a Wishbone classic port.
module stream_capture_buffer #(
  parameter int          DEPTH    = 512,
  parameter logic [31:0] ID_VALUE = 32'h5343_4150
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     capture_i,
  output logic                     done_o,
  stream_capture_buffer_if.slave   bus
);
  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] LEN_MAX = 9'(DEPTH - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CAPTURE = 2'd1, ST_DONE = 2'd2} cap_state_t;
  typedef enum logic [1:0] {BUS_IDLE = 2'd0, BUS_MEMRD = 2'd1, BUS_TERM = 2'd2} bus_state_t;

  cap_state_t   state_r, state_s;
  bus_state_t   bus_r, bus_s;
  logic [9:0]   count_r, count_s;
  logic [8:0]   len_lat_r, len_lat_s;
  logic [8:0]   length_r;
  logic         enable_r;
  logic [127:0] mem_r [DEPTH];
  logic [127:0] rd_beat_r;
  logic [1:0]   lane_r;
  logic         mem_we_s, mem_rd_s, reg_wr_s;
  logic         req_s, trig_wr_s, clear_wr_s, trig_s;
  logic [31:0]  reg_rdata_s, dat_s;
  logic         ack_s, err_s, rty_s;
  logic         unused_s;

  assign bus.buf_tready = 1'b1;
  assign req_s      = bus.wb_cyc_i & bus.wb_stb_i;
  assign trig_wr_s  = reg_wr_s & (bus.wb_adr_i[1:0] == 2'd0) & bus.wb_dat_i[1];
  assign clear_wr_s = reg_wr_s & (bus.wb_adr_i[1:0] == 2'd0) & bus.wb_dat_i[2];
  assign trig_s     = capture_i | trig_wr_s;
  assign unused_s   = ^{bus.wb_sel_i, bus.wb_adr_i, bus.wb_dat_i};

  // Register read mux
  always_comb begin
    reg_rdata_s = 32'd0;
    case (bus.wb_adr_i[1:0])
      2'd0:    reg_rdata_s = {31'd0, enable_r};
      2'd1:    reg_rdata_s = {6'd0, count_r, 14'd0, state_r};
      2'd2:    reg_rdata_s = {23'd0, length_r};
      2'd3:    reg_rdata_s = ID_VALUE;
      default: reg_rdata_s = 32'd0;
    endcase
  end

  // Capture FSM next state; CLEAR outranks any trigger in the same cycle
  always_comb begin
    state_s   = state_r;
    count_s   = count_r;
    len_lat_s = len_lat_r;
    mem_we_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (trig_s && enable_r && !clear_wr_s) begin
          state_s   = ST_CAPTURE;
          count_s   = 10'd0;
          len_lat_s = (length_r > LEN_MAX) ? LEN_MAX : length_r;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (clear_wr_s) begin
          state_s = ST_IDLE;
          count_s = 10'd0;
        end else if (bus.buf_tvalid) begin
          mem_we_s = 1'b1;
          count_s  = count_r + 10'd1;
          if (count_r == {1'b0, len_lat_r}) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_CAPTURE;
          end
        end else begin
          state_s = ST_CAPTURE;
        end
      end
      ST_DONE: begin
        if (clear_wr_s) begin
          state_s = ST_IDLE;
          count_s = 10'd0;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        count_s = 10'd0;
      end
    endcase
  end

  // Bus FSM: BUS_TERM holds the terminator for one cycle and forces a gap before the next request
  always_comb begin
    bus_s    = bus_r;
    ack_s    = 1'b0;
    err_s    = 1'b0;
    rty_s    = 1'b0;
    dat_s    = 32'd0;
    reg_wr_s = 1'b0;
    mem_rd_s = 1'b0;
    case (bus_r)
      BUS_IDLE: begin
        if (!req_s) begin
          bus_s = BUS_IDLE;
        end else if (!bus.wb_adr_i[12]) begin
          ack_s = 1'b1;
          bus_s = BUS_TERM;
          if (bus.wb_we_i) begin
            reg_wr_s = 1'b1;
          end else begin
            dat_s = reg_rdata_s;
          end
        end else if (bus.wb_we_i) begin
          err_s = 1'b1;
          bus_s = BUS_TERM;
        end else if (state_r == ST_CAPTURE) begin
          rty_s = 1'b1;
          bus_s = BUS_TERM;
        end else begin
          mem_rd_s = 1'b1;
          bus_s    = BUS_MEMRD;
        end
      end
      BUS_MEMRD: begin
        if (req_s) begin
          ack_s = 1'b1;
          dat_s = rd_beat_r[{lane_r, 5'd0} +: 32];
          bus_s = BUS_TERM;
        end else begin
          bus_s = BUS_IDLE;
        end
      end
      BUS_TERM: bus_s = BUS_IDLE;
      default:  bus_s = BUS_IDLE;
    endcase
  end

  // Capture state, beat counter and latched length
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r   <= ST_IDLE;
      count_r   <= 10'd0;
      len_lat_r <= LEN_MAX;
      done_o    <= 1'b0;
    end else begin
      state_r   <= state_s;
      count_r   <= count_s;
      len_lat_r <= len_lat_s;
      done_o    <= (state_s == ST_DONE);
    end
  end

  // Writable control registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      enable_r <= 1'b0;
      length_r <= LEN_MAX;
    end else if (reg_wr_s) begin
      case (bus.wb_adr_i[1:0])
        2'd0:    enable_r <= bus.wb_dat_i[0];
        2'd2:    length_r <= bus.wb_dat_i[8:0];
        default: ;
      endcase
    end
  end

  // Bus state and registered Wishbone outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bus_r        <= BUS_IDLE;
      bus.wb_ack_o <= 1'b0;
      bus.wb_err_o <= 1'b0;
      bus.wb_rty_o <= 1'b0;
      bus.wb_dat_o <= 32'd0;
    end else begin
      bus_r        <= bus_s;
      bus.wb_ack_o <= ack_s;
      bus.wb_err_o <= err_s;
      bus.wb_rty_o <= rty_s;
      bus.wb_dat_o <= dat_s;
    end
  end

  // Capture memory: stream write port and registered bus read port, contents survive reset
  always_ff @(posedge aclk) begin
    if (mem_we_s) begin
      mem_r[count_r[AW-1:0]] <= bus.buf_tdata;
    end
    if (mem_rd_s) begin
      rd_beat_r <= mem_r[bus.wb_adr_i[2 +: AW]];
      lane_r    <= bus.wb_adr_i[1:0];
    end
  end
endmodule

// File: tb/tb_stream_capture_buffer.sv
// Self-checking bench for stream_capture_buffer with a behavioural capture model.
module tb_stream_capture_buffer;
  localparam int DEPTH = 512;
  localparam logic [31:0] ID = 32'h5343_4150;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic capture_i = 1'b0;
  logic done_o;
  stream_capture_buffer_if bus();

  stream_capture_buffer #(.DEPTH(DEPTH), .ID_VALUE(ID)) dut (
    .aclk(aclk), .aresetn(aresetn), .capture_i(capture_i), .done_o(done_o), .bus(bus)
  );

  always #5 aclk = ~aclk;

  int n_pass = 0;
  int n_total = 0;
  // model: state 0 IDLE / 1 CAPTURE / 2 DONE, beat count, latched and programmed length
  int m_state, m_count, m_len, m_length;
  bit m_en;
  logic [127:0] mmem [DEPTH];
  logic [31:0] rd;
  logic [2:0] term;
  int lat;

  function automatic logic [127:0] rand_beat();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [31:0] exp_word(int w);
    logic [127:0] b;
    b = mmem[(w / 4) % DEPTH];
    return b[32 * (w % 4) +: 32];
  endfunction

  function automatic logic [31:0] exp_status();
    return (32'(m_count) << 16) | 32'(m_state);
  endfunction

  task automatic model_reset();
    m_state = 0; m_count = 0; m_en = 1'b0; m_length = DEPTH - 1; m_len = DEPTH - 1;
  endtask

  task automatic model_start();
    m_state = 1; m_count = 0;
    m_len = (m_length > DEPTH - 1) ? DEPTH - 1 : m_length;
  endtask

  task automatic cycle_stream(input bit v, input logic [127:0] d, input bit cap);
    @(negedge aclk);
    bus.buf_tvalid = v; bus.buf_tdata = d; capture_i = cap;
    @(posedge aclk);
    if (m_state == 1 && v) begin
      mmem[m_count % DEPTH] = d;
      if (m_count == m_len) m_state = 2;
      m_count++;
    end else if (m_state == 0 && cap && m_en) begin
      model_start();
    end
    #1;
    bus.buf_tvalid = 1'b0; capture_i = 1'b0;
  endtask

  task automatic wb_xfer(input bit we, input logic [12:0] adr, input logic [31:0] dat, input bit cap,
                         output logic [31:0] rdat, output logic [2:0] t, output int l);
    @(negedge aclk);
    bus.buf_tvalid = 1'b0; capture_i = cap;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
    bus.wb_adr_i = adr; bus.wb_dat_i = dat; bus.wb_sel_i = 4'hF;
    t = 3'b000; l = 0; rdat = 32'd0;
    for (int i = 1; i <= 6; i++) begin
      if (t == 3'b000) begin
        @(posedge aclk); #1;
        capture_i = 1'b0;
        if ({bus.wb_ack_o, bus.wb_err_o, bus.wb_rty_o} != 3'b000) begin
          t = {bus.wb_ack_o, bus.wb_err_o, bus.wb_rty_o}; rdat = bus.wb_dat_o; l = i;
        end
      end
    end
    @(negedge aclk);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d, input bit cap, output logic [2:0] t);
    logic [31:0] r;
    int l;
    wb_xfer(1'b1, {11'd0, a}, d, cap, r, t, l);
    if (a == 2'd0) begin
      if (d[2] && m_state != 0) begin
        m_state = 0; m_count = 0;
      end else if ((d[1] || cap) && !d[2] && m_state == 0 && m_en) begin
        model_start();
      end
      m_en = d[0];
    end else if (a == 2'd2) begin
      m_length = int'(d[8:0]);
    end
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [31:0] r, output logic [2:0] t, output int l);
    wb_xfer(1'b0, {11'd0, a}, 32'd0, 1'b0, r, t, l);
  endtask

  task automatic mem_rd(input int w, output logic [31:0] r, output logic [2:0] t, output int l);
    wb_xfer(1'b0, 13'h1000 | 13'(w), 32'd0, 1'b0, r, t, l);
  endtask

  task automatic test_reset();
    n_total++;
    if ({done_o, bus.wb_ack_o, bus.wb_err_o, bus.wb_rty_o, bus.wb_dat_o} !== 36'd0)
      $display("FAIL reset_outputs: got %h expected 0", {done_o, bus.wb_ack_o, bus.wb_err_o, bus.wb_rty_o, bus.wb_dat_o});
    else n_pass++;
    reg_rd(2'd1, rd, term, lat); n_total++;
    if ({term, 4'(lat), rd} !== {3'b100, 4'd1, 32'd0}) $display("FAIL reset_status: got %h expected %h", {term, 4'(lat), rd}, {3'b100, 4'd1, 32'd0}); else n_pass++;
    reg_rd(2'd0, rd, term, lat); n_total++;
    if (rd !== 32'd0) $display("FAIL reset_ctrl: got %h expected 0", rd); else n_pass++;
    reg_rd(2'd2, rd, term, lat); n_total++;
    if (rd !== 32'd511) $display("FAIL reset_length: got %h expected 1ff", rd); else n_pass++;
    reg_rd(2'd3, rd, term, lat); n_total++;
    if ({term, 4'(lat), rd} !== {3'b100, 4'd1, ID}) $display("FAIL id_read: got %h expected %h", {term, 4'(lat), rd}, {3'b100, 4'd1, ID}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [5:0] pat = 6'd0;
    @(negedge aclk);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = 13'd3;
    for (int i = 0; i < 6; i++) begin
      @(posedge aclk); #1;
      pat = {pat[4:0], bus.wb_ack_o | bus.wb_err_o | bus.wb_rty_o};
      if (i == 2) begin
        @(negedge aclk);
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
      end
    end
    n_total++;
    if (pat !== 6'b101000) $display("FAIL back_to_back_term: got %b expected 101000", pat); else n_pass++;
  endtask

  task automatic test_basic();
    logic [127:0] b;
    reg_wr(2'd2, 32'd3, 1'b0, term);
    reg_wr(2'd0, 32'd1, 1'b0, term);
    cycle_stream(1'b0, 128'd0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      for (int s = 0; s < 8; s++) b[16 * s +: 16] = 16'(k * 256 + s);
      cycle_stream(1'b1, b, 1'b0);
    end
    for (int k = 0; k < 3; k++) cycle_stream(1'b1, rand_beat(), 1'b0);
    reg_rd(2'd1, rd, term, lat); n_total++;
    if (rd !== 32'h0004_0002) $display("FAIL basic_status: got %h expected 00040002", rd); else n_pass++;
    n_total++;
    if (done_o !== 1'b1) $display("FAIL basic_done: got %b expected 1", done_o); else n_pass++;
    for (int w = 0; w < 16; w++) begin
      mem_rd(w, rd, term, lat); n_total++;
      if ({term, 4'(lat), rd} !== {3'b100, 4'd2, 16'(w / 4 + 1) * 16'd256 + 16'(2 * (w % 4) + 1), 16'(w / 4 + 1) * 16'd256 + 16'(2 * (w % 4))})
        $display("FAIL basic_mem[%0d]: got %h expected ack lat2 data %h", w, {term, 4'(lat), rd}, exp_word(w));
      else n_pass++;
    end
  endtask

  task automatic test_gaps();
    reg_wr(2'd0, 32'd5, 1'b0, term);
    reg_wr(2'd2, 32'($urandom_range(8, 20)), 1'b0, term);
    cycle_stream(1'b0, 128'd0, 1'b1);
    reg_wr(2'd2, 32'($urandom_range(0, 3)), 1'b0, term);
    for (int i = 0; i < 3; i++) cycle_stream(1'b1, rand_beat(), 1'b0);
    for (int i = 0; i < 5; i++) cycle_stream(1'b0, rand_beat(), 1'b0);
    reg_rd(2'd1, rd, term, lat); n_total++;
    if (rd !== 32'h0003_0001) $display("FAIL gap_count: got %h expected 00030001", rd); else n_pass++;
    for (int i = 0; i < 100 && m_state == 1; i++) cycle_stream(1'b1, rand_beat(), 1'b0);
    reg_rd(2'd1, rd, term, lat); n_total++;
    if (rd !== exp_status()) $display("FAIL gap_status: got %h expected %h", rd, exp_status()); else n_pass++;
    for (int w = 0; w < m_count * 4; w++) begin
      mem_rd(w, rd, term, lat); n_total++;
      if (rd !== exp_word(w)) $display("FAIL gap_mem[%0d]: got %h expected %h", w, rd, exp_word(w)); else n_pass++;
    end
  endtask

  task automatic test_enable_trig();
    reg_wr(2'd0, 32'd4, 1'b0, term);
    reg_wr(2'd2, 32'd2, 1'b0, term);
    cycle_stream(1'b0, 128'd0, 1'b1);
    reg_rd(2'd1, rd, term, lat); n_total++;
    if (rd !== 32'd0) $display("FAIL disabled_trigger: got %h expected 0", rd); else n_pass++;
    reg_wr(2'd0, 32'd1, 1'b0, term);
    reg_wr(2'd0, 32'd3, 1'b0, term);
    reg_rd(2'd1, rd, term, lat); n_total++;
    if (rd !== 32'd1) $display("FAIL ctrl_trig: got %h expected 1", rd); else n_pass++;
  endtask

  task automatic test_bus_errors();
    mem_rd(0, rd, term, lat); n_total++;
    if ({term, rd} !== {3'b001, 32'd0}) $display("FAIL mem_rd_capture_rty: got %h expected %h", {term, rd}, {3'b001, 32'd0}); else n_pass++;
    wb_xfer(1'b1, 13'h1004, 32'hDEAD_BEEF, 1'b0, rd, term, lat); n_total++;
    if (term !== 3'b010) $display("FAIL mem_wr_err: got %b expected 010", term); else n_pass++;
    reg_wr(2'd1, 32'hFFFF_FFFF, 1'b0, term); n_total++;
    if (term !== 3'b100) $display("FAIL ro_write_ack: got %b expected 100", term); else n_pass++;
    reg_rd(2'd1, rd, term, lat); n_total++;
    if (rd !== 32'd1) $display("FAIL ro_write_ignored: got %h expected 1", rd); else n_pass++;
    reg_rd(2'd3, rd, term, lat); n_total++;
    if ({term, 4'(lat), rd} !== {3'b100, 4'd1, ID}) $display("FAIL id_in_capture: got %h expected %h", {term, 4'(lat), rd}, {3'b100, 4'd1, ID}); else n_pass++;
    for (int i = 0; i < 20 && m_state == 1; i++) cycle_stream(1'b1, rand_beat(), 1'b0);
    reg_rd(2'd1, rd, term, lat); n_total++;
    if ({done_o, rd} !== {1'b1, 32'h0003_0002}) $display("FAIL len2_done: got %h expected %h", {done_o, rd}, {1'b1, 32'h0003_0002}); else n_pass++;
  endtask

  task automatic test_clear_trig();
    reg_wr(2'd0, 32'd5, 1'b1, term);
    reg_rd(2'd1, rd, term, lat); n_total++;
    if (rd !== 32'd0) $display("FAIL clear_status: got %h expected 0", rd); else n_pass++;
    for (int i = 0; i < 3; i++) cycle_stream(1'b1, rand_beat(), 1'b0);
    reg_rd(2'd1, rd, term, lat); n_total++;
    if ({done_o, rd} !== 33'd0) $display("FAIL clear_no_capture: got %h expected 0", {done_o, rd}); else n_pass++;
  endtask

  task automatic test_random();
    int ln;
    for (int it = 0; it < 4; it++) begin
      reg_wr(2'd0, 32'd5, 1'b0, term);
      ln = (it == 0) ? 0 : int'($urandom_range(1, 15));
      reg_wr(2'd2, 32'(ln), 1'b0, term);
      if ($urandom_range(0, 1) == 0) cycle_stream(1'b0, 128'd0, 1'b1);
      else reg_wr(2'd0, 32'd3, 1'b0, term);
      for (int i = 0; i < 200 && m_state == 1; i++)
        cycle_stream($urandom_range(0, 9) < 7, rand_beat(), $urandom_range(0, 1) == 1);
      for (int i = 0; i < 3; i++) cycle_stream(1'b1, rand_beat(), 1'b1);
      reg_rd(2'd1, rd, term, lat); n_total++;
      if ({done_o, rd} !== {1'b1, exp_status()}) $display("FAIL rand_status[%0d]: got %h expected %h", it, {done_o, rd}, {1'b1, exp_status()}); else n_pass++;
      for (int k = 0; k < 6; k++) begin
        int w = int'($urandom_range(0, 32'(m_count * 4 - 1)));
        mem_rd(w, rd, term, lat); n_total++;
        if (rd !== exp_word(w)) $display("FAIL rand_mem[%0d]: got %h expected %h", w, rd, exp_word(w)); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    reg_wr(2'd0, 32'd5, 1'b0, term);
    reg_wr(2'd2, 32'd10, 1'b0, term);
    cycle_stream(1'b0, 128'd0, 1'b1);
    for (int i = 0; i < 4; i++) cycle_stream(1'b1, rand_beat(), 1'b0);
    @(negedge aclk); aresetn = 1'b0; model_reset(); #1;
    n_total++;
    if ({done_o, bus.wb_ack_o, bus.wb_err_o, bus.wb_rty_o} !== 4'd0) $display("FAIL reset_mid_outputs: got %b expected 0000", {done_o, bus.wb_ack_o, bus.wb_err_o, bus.wb_rty_o}); else n_pass++;
    @(negedge aclk); aresetn = 1'b1;
    reg_rd(2'd1, rd, term, lat); n_total++;
    if (rd !== 32'd0) $display("FAIL reset_mid_status: got %h expected 0", rd); else n_pass++;
    reg_rd(2'd2, rd, term, lat); n_total++;
    if (rd !== 32'd511) $display("FAIL reset_mid_length: got %h expected 1ff", rd); else n_pass++;
    mem_rd(5, rd, term, lat); n_total++;
    if ({term, 4'(lat), rd} !== {3'b100, 4'd2, exp_word(5)}) $display("FAIL mem_survives_reset: got %h expected %h", {term, 4'(lat), rd}, {3'b100, 4'd2, exp_word(5)}); else n_pass++;
    @(negedge aclk);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = 13'h1000;
    @(posedge aclk);
    @(negedge aclk); aresetn = 1'b0;
    repeat (2) begin @(posedge aclk); #1; seen = seen | bus.wb_ack_o | bus.wb_err_o | bus.wb_rty_o; end
    @(negedge aclk); bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; aresetn = 1'b1;
    repeat (2) begin @(posedge aclk); #1; seen = seen | bus.wb_ack_o | bus.wb_err_o | bus.wb_rty_o; end
    n_total++;
    if (seen !== 1'b0) $display("FAIL reset_mid_xfer_term: got %b expected 0", seen); else n_pass++;
  endtask

  initial begin
    bus.buf_tdata = 128'd0; bus.buf_tvalid = 1'b0;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = 13'd0; bus.wb_dat_i = 32'd0; bus.wb_sel_i = 4'd0;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk); aresetn = 1'b1;
    model_reset();
    test_reset();
    test_back_to_back();
    test_basic();
    test_gaps();
    test_enable_trig();
    test_bus_errors();
    test_clear_trig();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
